// File: rtl/dma_axi_mem_slave.sv
// AXI4 responder backed by a 64-bit-word register memory, serving one FIXED/INCR burst at a time.
// Optional out-of-range checking against BASE_ADDR is enabled by defining DMA_AXI_MEM_SLAVE_ERR_EN.

package ariane_axi;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module dma_axi_mem_slave #(
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned AXI_LEN_WIDTH  = 8,
    parameter logic [63:0] BASE_ADDR      = 64'h0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  ariane_axi::req_t  axi_req_i,
    output ariane_axi::resp_t axi_resp_o,
    output logic              busy_o
);
    localparam int unsigned DEPTH = 1 << MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, W_DATA, B_RESP, R_DATA} state_e;

    state_e                          state_q, state_d;
    logic [63:0]                     mem_q [DEPTH];
    logic [ariane_axi::IdWidth-1:0]  id_q, id_d;
    logic [AXI_LEN_WIDTH-1:0]        cnt_q, cnt_d;
    logic                            incr_q, incr_d;
    logic                            err_q, err_d;
    logic [MEM_ADDR_WIDTH-1:0]       idx;
    logic                            beat_oor;
    logic                            aw_acc, ar_acc, w_fire, r_fire, last_beat;
    logic [7:0]                      wr_be;
    logic                            unused_req;

    // Writes take priority over reads when both address channels are valid in IDLE.
    assign aw_acc    = (state_q == IDLE) && axi_req_i.aw_valid;
    assign ar_acc    = (state_q == IDLE) && !axi_req_i.aw_valid && axi_req_i.ar_valid;
    assign w_fire    = (state_q == W_DATA) && axi_req_i.w_valid;
    assign r_fire    = (state_q == R_DATA) && axi_req_i.r_ready;
    assign last_beat = (cnt_q == '0);
    assign busy_o    = (state_q != IDLE);
    assign unused_req = ^{axi_req_i, BASE_ADDR};

`ifdef DMA_AXI_MEM_SLAVE_ERR_EN
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) << 3;
    logic [63:0] off_q, off_d;

    // Byte offset is tracked at full width so beats running past the top stay out of range.
    always_comb begin
        off_d = off_q;
        if (aw_acc) begin
            off_d = axi_req_i.aw.addr - BASE_ADDR;
        end else if (ar_acc) begin
            off_d = axi_req_i.ar.addr - BASE_ADDR;
        end else if ((w_fire || r_fire) && incr_q) begin
            off_d = off_q + 64'd8;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    assign idx      = off_q[3 +: MEM_ADDR_WIDTH];
    assign beat_oor = (off_q >= MEM_BYTES);
`else
    logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (aw_acc) begin
            idx_d = axi_req_i.aw.addr[3 +: MEM_ADDR_WIDTH];
        end else if (ar_acc) begin
            idx_d = axi_req_i.ar.addr[3 +: MEM_ADDR_WIDTH];
        end else if ((w_fire || r_fire) && incr_q) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx      = idx_q;
    assign beat_oor = 1'b0;
`endif

    always_comb begin
        id_d   = id_q;
        cnt_d  = cnt_q;
        incr_d = incr_q;
        err_d  = err_q;
        if (aw_acc) begin
            id_d   = axi_req_i.aw.id;
            cnt_d  = AXI_LEN_WIDTH'(axi_req_i.aw.len);
            incr_d = (axi_req_i.aw.burst != 2'b00);
            err_d  = 1'b0;
        end else if (ar_acc) begin
            id_d   = axi_req_i.ar.id;
            cnt_d  = AXI_LEN_WIDTH'(axi_req_i.ar.len);
            incr_d = (axi_req_i.ar.burst != 2'b00);
            err_d  = 1'b0;
        end else if (w_fire || r_fire) begin
            if (!last_beat) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (w_fire && beat_oor) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q   <= '0;
            cnt_q  <= '0;
            incr_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            id_q   <= id_d;
            cnt_q  <= cnt_d;
            incr_q <= incr_d;
            err_q  <= err_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_be
            assign wr_be[gi] = w_fire && !beat_oor && axi_req_i.w.strb[gi];
        end
    endgenerate

    // Storage is deliberately left unreset; contents survive a reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 8; b++) begin
            if (wr_be[b]) begin
                mem_q[idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (axi_req_i.aw_valid) begin
                    state_d = W_DATA;
                end else if (axi_req_i.ar_valid) begin
                    state_d = R_DATA;
                end
            end
            W_DATA: if (axi_req_i.w_valid && last_beat) state_d = B_RESP;
            B_RESP: if (axi_req_i.b_ready) state_d = IDLE;
            R_DATA: if (axi_req_i.r_ready && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        axi_resp_o = '0;
        case (state_q)
            IDLE: begin
                axi_resp_o.aw_ready = 1'b1;
                axi_resp_o.ar_ready = !axi_req_i.aw_valid;
            end
            W_DATA: axi_resp_o.w_ready = 1'b1;
            B_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b.id    = id_q;
                axi_resp_o.b.resp  = err_q ? 2'b10 : 2'b00;
            end
            R_DATA: begin
                axi_resp_o.r_valid = 1'b1;
                axi_resp_o.r.id    = id_q;
                axi_resp_o.r.data  = beat_oor ? 64'h0 : mem_q[idx];
                axi_resp_o.r.resp  = beat_oor ? 2'b10 : 2'b00;
                axi_resp_o.r.last  = last_beat;
            end
            default: axi_resp_o = '0;
        endcase
    end
endmodule

// File: doc/dma_axi_mem_slave.md
Name: dma_axi_mem_slave

Overview:
- AXI4 responder (slave) backed by a 64-bit-word register memory; the target-side counterpart of the DMA AXI initiator.
- Serves single (FIXED) and burst (INCR) reads and writes, one transaction at a time.
- Used as the DMA engine's memory model in block/subsystem benches and as a small scratchpad behind the ariane_axi crossbar.

Parameters:
- MEM_ADDR_WIDTH, 8, log2 of memory depth in 64-bit words (default 256 words = max burst of 2**AXI_LEN_WIDTH beats).
- AXI_LEN_WIDTH, 8, width of AxLEN and of the internal beat counter.
- BASE_ADDR, 64'h0, byte address of word 0; only used when DMA_AXI_MEM_SLAVE_ERR_EN is defined.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- axi_req_i  input  ariane_axi::req_t  AW/W/AR channels plus b_ready/r_ready from the initiator.
- axi_resp_o  output  ariane_axi::resp_t  aw_ready/w_ready/ar_ready, B and R channels.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, W_DATA, B_RESP, R_DATA. Reset → IDLE.
- Memory contents are not reset.
- Reset output values:
  - aw_ready=1, ar_ready=1 (IDLE decode).
  - w_ready=0, b_valid=0, r_valid=0, r.last=0, busy_o=0.
  - All id/resp/data fields 0.
  - Unused resp fields are tied to 0.
- IDLE:
  - aw_ready=ar_ready=1, w_ready=0.
  - If aw_valid: accept AW and go to W_DATA. Writes win when aw_valid and ar_valid are asserted in the same cycle; ar_ready drops to 0 that cycle.
  - Otherwise, if ar_valid: accept AR and go to R_DATA.
  - On accept, latch id, word index = addr[3 +: MEM_ADDR_WIDTH] (addr minus BASE_ADDR when the feature is enabled), cnt=len, and incr flag = (burst != 2'b00). WRAP is treated as INCR.
  - size is ignored; every beat is one 64-bit word.
- W_DATA:
  - w_ready=1. W data presented during IDLE is not consumed until W_DATA.
  - On w_valid: bytes i with strb[i]=1 are written into mem[idx].
  - If incr, idx increments modulo depth.
  - If cnt==0, go to B_RESP; otherwise cnt decrements.
  - cnt is authoritative: w.last is ignored for termination.
- B_RESP:
  - b_valid=1, b.id=latched id, b.resp=2'b00 (OKAY).
  - On b_ready, go to IDLE. Earliest next AW accept is the following cycle.
- R_DATA:
  - r_valid=1, r.data=mem[idx] (combinational read), r.id=latched id, r.resp=OKAY, r.last=(cnt==0).
  - On r_ready: idx advances if incr, cnt decrements.
  - The beat with r.last=1 returns to IDLE.
  - r.data is held stable while r_ready=0.
- Latency:
  - Single write: AW accept cycle, then ≥1 W cycle, then ≥1 B cycle.
  - Read: first R beat valid the cycle after AR accept. Zero-wait bursts run one beat per cycle.
- Boundary conditions:
  - A burst crossing the top of memory wraps to word 0.
  - len=255 is supported (256 beats).
  - Reset mid-burst aborts the transaction and drops all valids; already-written words persist.

Optional Feature:
- Macro: DMA_AXI_MEM_SLAVE_ERR_EN.
- Defined:
  - A beat whose byte address (addr minus BASE_ADDR, tracked per beat) is ≥ depth*8 or below BASE_ADDR is out of range.
  - Out-of-range write beats are suppressed; B returns 2'b10 (SLVERR) if any beat of the burst was out of range.
  - Out-of-range read beats return data 0 with r.resp=2'b10.
  - Beat count and handshakes are unchanged.
- Not defined: BASE_ADDR is ignored, addresses wrap modulo depth, and every response is OKAY.

Test Plan:
- Single write: addr 0x40, data 64'hDEADBEEF_01234567, strb 8'hFF, FIXED, len 0, id 3 → mem[8] updated; one B with id 3, OKAY; then single read of 0x40 returns the same data with r.last=1.
- INCR write, len 3, addr 0x100, data 1..4, strb 8'h0F on beat 2 → mem[32..35] = 1, 2, {old[63:32], lower half of 3}, 4. INCR read, len 3 returns those words with r.last only on beat 4.
- Backpressure: r_ready toggled 1,0,0,1 during a 4-beat read → r.data is stable while stalled, exactly 4 beats, no skipped or repeated beats.
- Simultaneous aw_valid and ar_valid in IDLE → AW accepted, ar_ready=0; AR accepted in the cycle after the B handshake.
- Wrap and reset: INCR write, len 3, at word 254 → words 254, 255, 0, 1 written. A 4-beat read then reset after beat 2 → r_valid=0, busy_o=0, aw_ready=ar_ready=1.
- With DMA_AXI_MEM_SLAVE_ERR_EN, BASE_ADDR=0x1000: read at 0x0800 → r.resp=2'b10, data 0. Write burst straddling the top word → in-range beat written, B resp 2'b10.
